enc_gray_codec: RTL

ENC_GRAY_CODEC -- requirements
Module: enc_gray_codec

---
 rtl/enc_gray_codec.sv | 89 ++++++++
 1 files changed

// File: rtl/enc_gray_codec.sv
// Binary/Gray codec with a two-stage valid/ready pipeline.
// Each word carries its own conversion mode; output transfers are counted.
module enc_gray_codec #(
    parameter int WIDTH = 10,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_mode,
    output logic [CNT_W-1:0] xfer_cnt
);

    logic             s1_v;
    logic             s1_m;
    logic [WIDTH-1:0] s1_d;
    logic             s2_v;
    logic             s2_m;
    logic [WIDTH-1:0] s2_d;
    logic [WIDTH-1:0] conv;
    logic             s2_load;
    logic             s1_load;
    logic             out_xfer;

    assign out_xfer = s2_v & out_ready;
    assign s2_load  = ~s2_v | out_ready;
    assign s1_load  = ~s1_v | s2_load;
    // Gated so the block never advertises space while held in reset.
    assign in_ready = ~rst & s1_load;

    always_comb begin
        conv = '0;
        if (s1_m) begin
            conv[WIDTH-1] = s1_d[WIDTH-1];
            for (int i = WIDTH - 2; i >= 0; i--) begin
                conv[i] = conv[i+1] ^ s1_d[i];
            end
        end else begin
            conv = s1_d ^ (s1_d >> 1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_v <= 1'b0;
            s1_m <= 1'b0;
            s1_d <= '0;
        end else if (s1_load) begin
            s1_v <= in_valid;
            if (in_valid) begin
                s1_d <= in_data;
                s1_m <= in_mode;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_v <= 1'b0;
            s2_m <= 1'b0;
            s2_d <= '0;
        end else if (s2_load) begin
            s2_v <= s1_v;
            if (s1_v) begin
                s2_d <= conv;
                s2_m <= s1_m;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xfer_cnt <= '0;
        end else if (out_xfer && !(&xfer_cnt)) begin
            xfer_cnt <= xfer_cnt + 1'b1;
        end
    end

    assign out_valid = s2_v;
    assign out_data  = s2_d;
    assign out_mode  = s2_m;

endmodule
